// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one digit per scan slot, active-low
// anodes, blink support and double-buffered code updates committed at frame end.
module seg_scan_ctrl #(
  parameter int N_DIGITS  = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [5*N_DIGITS-1:0] codes_in,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [4:0]            code_out,
  output logic [N_DIGITS-1:0]   an,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  active_q, active_d;
  logic [5*N_DIGITS-1:0] staging_q, staging_d;
  logic [5*N_DIGITS-1:0] display_q, display_d;
  logic                  pending_q, pending_d;
  logic [4:0]            code_out_q, code_out_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic tick;
  logic last_digit;
  logic commit;

  always_comb begin
    presc_d       = presc_q;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    staging_d     = staging_q;
    display_d     = display_q;
    pending_d     = pending_q;
    code_out_d    = code_out_q;
    an_d          = an_q;
    active_d      = enable;

    // active_q marks the first enabled cycle: prescaler stays at 0 there so the
    // first slot after reset or re-enable is visible for a full SCAN_DIV cycles.
    tick         = enable && active_q && (presc_q == PRESC_MAX);
    last_digit   = (idx_q == IDX_MAX);
    frame_done_d = tick && last_digit;

    if (!enable) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (active_q) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        idx_d = last_digit ? '0 : idx_q + IW'(1);
      end
    end

    if (tick) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    commit = pending_q && ((tick && last_digit) || !enable);
    if (commit) begin
      display_d = staging_q;
      pending_d = 1'b0;
    end
    if (load) begin
      staging_d = codes_in;
      pending_d = 1'b1;
    end

    if (!enable) begin
      an_d       = '1;
      code_out_d = display_d[4:0];
    end else if (tick || !active_q) begin
      code_out_d = display_d[idx_d*5 +: 5];
      an_d       = (blink_phase_d && blink_mask[idx_d]) ? '1
                                                        : ~(N_DIGITS'(1) << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      active_q      <= 1'b0;
      staging_q     <= '0;
      display_q     <= '0;
      pending_q     <= 1'b0;
      code_out_q    <= 5'h00;
      an_q          <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      active_q      <= active_d;
      staging_q     <= staging_d;
      display_q     <= display_d;
      pending_q     <= pending_d;
      code_out_q    <= code_out_d;
      an_q          <= an_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign code_out   = code_out_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (N_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2).
// Edge numbers E<n> count rising edges after reset release.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [19:0] codes_in;
  logic        load;
  logic [3:0]  blink_mask;
  logic [4:0]  code_out;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  seg_scan_ctrl #(.N_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .codes_in   (codes_in),
    .load       (load),
    .blink_mask (blink_mask),
    .code_out   (code_out),
    .an         (an),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; codes_in = '0; load = 1'b0; blink_mask = '0;
    clk_n(2);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_code", 32'(code_out), 32'h0);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0; enable = 1'b1;

    clk_n(1); chk("e1_an", 32'(an), 32'b1110); chk("e1_code", 32'(code_out), 32'h0);
    clk_n(3); chk("e4_an_full_slot", 32'(an), 32'b1110);
    clk_n(1); chk("e5_an", 32'(an), 32'b1101);
    clk_n(4); chk("e9_an", 32'(an), 32'b1011);
    clk_n(4); chk("e13_an", 32'(an), 32'b0111); chk("e13_fd", 32'(frame_done), 32'h0);
    clk_n(3); chk("e16_fd", 32'(frame_done), 32'h0);
    clk_n(1); chk("e17_an", 32'(an), 32'b1110); chk("e17_fd", 32'(frame_done), 32'h1);
    chk("e17_code", 32'(code_out), 32'h0);
    clk_n(1); chk("e18_fd", 32'(frame_done), 32'h0);

    // load {3,2,1,0} while digit 1 is showing
    clk_n(3); chk("e21_an", 32'(an), 32'b1101);
    codes_in = {5'd3, 5'd2, 5'd1, 5'd0}; load = 1'b1;
    clk_n(1); load = 1'b0;
    chk("e22_pend", 32'(pending), 32'h1); chk("e22_code", 32'(code_out), 32'h0);
    clk_n(3); chk("e25_code_old", 32'(code_out), 32'h0);
    clk_n(4); chk("e29_code_old", 32'(code_out), 32'h0);
    clk_n(4); chk("e33_pend", 32'(pending), 32'h0); chk("e33_fd", 32'(frame_done), 32'h1);
    chk("e33_code", 32'(code_out), 32'h0);
    clk_n(4); chk("e37_code", 32'(code_out), 32'd1);
    clk_n(4); chk("e41_code", 32'(code_out), 32'd2);

    // load A at digit 2, then B at digit 3: only B reaches the display
    codes_in = {5'h1F, 5'h1E, 5'h1D, 5'h1C}; load = 1'b1;
    clk_n(1); load = 1'b0; chk("e42_pend", 32'(pending), 32'h1);
    clk_n(3); chk("e45_code", 32'(code_out), 32'd3); chk("e45_an", 32'(an), 32'b0111);
    codes_in = {5'd4, 5'd5, 5'd6, 5'd7}; load = 1'b1;
    clk_n(1); load = 1'b0;
    clk_n(3); chk("e49_code_b0", 32'(code_out), 32'd7); chk("e49_pend", 32'(pending), 32'h0);
    blink_mask = 4'b0110;
    clk_n(4); chk("e53_an_lit", 32'(an), 32'b1101); chk("e53_code_b1", 32'(code_out), 32'd6);
    clk_n(4); chk("e57_an_dark", 32'(an), 32'b1111); chk("e57_code_b2", 32'(code_out), 32'd5);
    clk_n(1); chk("e58_an_dark", 32'(an), 32'b1111);
    clk_n(3); chk("e61_an_unmasked", 32'(an), 32'b0111); chk("e61_code_b3", 32'(code_out), 32'd4);
    clk_n(4); chk("e65_an", 32'(an), 32'b1110);
    clk_n(4); chk("e69_an_lit", 32'(an), 32'b1101);
    clk_n(4); chk("e73_an_dark", 32'(an), 32'b1111);
    blink_mask = 4'b0000;
    clk_n(1); chk("e74_mask_midslot", 32'(an), 32'b1111);
    clk_n(3); chk("e77_an", 32'(an), 32'b0111);

    // load C, then load D coincident with the commit tick
    codes_in = {5'd8, 5'd9, 5'd10, 5'd11}; load = 1'b1;
    clk_n(1); load = 1'b0; chk("e78_pend", 32'(pending), 32'h1);
    clk_n(2);
    codes_in = {5'h1C, 5'h1D, 5'h1E, 5'h1F}; load = 1'b1;
    clk_n(1); load = 1'b0;
    chk("e81_code_c0", 32'(code_out), 32'd11); chk("e81_pend", 32'(pending), 32'h1);
    chk("e81_fd", 32'(frame_done), 32'h1);
    clk_n(4); chk("e85_code_c1", 32'(code_out), 32'd10);
    clk_n(4); chk("e89_code_c2", 32'(code_out), 32'd9);
    clk_n(4); chk("e93_code_c3", 32'(code_out), 32'd8);
    clk_n(4); chk("e97_code_d0", 32'(code_out), 32'h1F); chk("e97_pend", 32'(pending), 32'h0);
    clk_n(4); chk("e101_code_d1", 32'(code_out), 32'h1E);

    // disable with a pending load: immediate commit, display dark
    codes_in = {5'h12, 5'h13, 5'h14, 5'h15}; load = 1'b1;
    clk_n(1); load = 1'b0; chk("e102_pend", 32'(pending), 32'h1);
    enable = 1'b0;
    clk_n(1); chk("e103_an_dark", 32'(an), 32'b1111); chk("e103_pend", 32'(pending), 32'h0);
    chk("e103_code", 32'(code_out), 32'h15); chk("e103_fd", 32'(frame_done), 32'h0);
    clk_n(1); chk("e104_an_dark", 32'(an), 32'b1111);
    enable = 1'b1;
    clk_n(1); chk("e105_an", 32'(an), 32'b1110); chk("e105_code", 32'(code_out), 32'h15);
    clk_n(3); chk("e108_an_full_slot", 32'(an), 32'b1110);
    clk_n(1); chk("e109_an", 32'(an), 32'b1101); chk("e109_code", 32'(code_out), 32'h14);

    // reset mid-frame discards staged codes
    codes_in = {5'd1, 5'd1, 5'd1, 5'd1}; load = 1'b1;
    clk_n(1); load = 1'b0; chk("e110_pend", 32'(pending), 32'h1);
    rst = 1'b1;
    clk_n(1); chk("e111_rst_an", 32'(an), 32'hF); chk("e111_rst_pend", 32'(pending), 32'h0);
    chk("e111_rst_code", 32'(code_out), 32'h0);
    rst = 1'b0;
    clk_n(1); chk("e112_an", 32'(an), 32'b1110); chk("e112_code", 32'(code_out), 32'h0);
    chk("e112_pend", 32'(pending), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
